// File: rtl/mc10_vram_arbiter.sv
// VRAM time-share arbiter for the MC-10: VDG fetches first, then posted CPU writes,
// then a single outstanding CPU read once the write FIFO has drained.
module mc10_vram_arbiter #(
   parameter int unsigned AW     = 13,
   parameter int unsigned DW     = 8,
   parameter int unsigned WDEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          vdg_fetch,
   input  logic [AW-1:0] vdg_addr,
   output logic [DW-1:0] vdg_dd,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_busy,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          wr_overflow,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int unsigned PW = $clog2(WDEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] fifo_addr [WDEPTH];
   logic [DW-1:0] fifo_data [WDEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          rd_pend_q, rd_pend_d;
   logic [AW-1:0] rd_addr_q;
   logic          rd_fly_q, vdg_fly_q;
   logic          busy_q, busy_d;
   logic          fifo_empty, pop, rd_issue, accept, push, rd_accept;

   always_comb begin
      fifo_empty = (count_q == '0);
      pop        = !vdg_fetch && !fifo_empty;
      rd_issue   = !vdg_fetch && fifo_empty && rd_pend_q;
      accept     = cpu_req && !busy_q;
      push       = accept && cpu_we;
      rd_accept  = accept && !cpu_we;
      count_d    = count_q + CW'(push) - CW'(pop);
      rd_pend_d  = rd_accept || (rd_pend_q && !rd_issue);
      // Next-cycle busy: FIFO full, a read waiting, or a read about to be in flight.
      busy_d     = (count_d == CW'(WDEPTH)) || rd_pend_d || rd_issue;
   end

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = vdg_addr;
      ram_wdata = fifo_data[rd_ptr_q];
      if (vdg_fetch) begin
         ram_en   = 1'b1;
         ram_addr = vdg_addr;
      end else if (!fifo_empty) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = fifo_addr[rd_ptr_q];
      end else if (rd_pend_q) begin
         ram_en   = 1'b1;
         ram_addr = rd_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr_q] <= cpu_addr;
         fifo_data[wr_ptr_q] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_pend_q   <= 1'b0;
         rd_addr_q   <= '0;
         rd_fly_q    <= 1'b0;
         vdg_fly_q   <= 1'b0;
         busy_q      <= 1'b0;
         cpu_rvalid  <= 1'b0;
         cpu_rdata   <= '0;
         vdg_dd      <= '0;
         wr_overflow <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_q + PW'(push);
         rd_ptr_q   <= rd_ptr_q + PW'(pop);
         count_q    <= count_d;
         rd_pend_q  <= rd_pend_d;
         if (rd_accept) rd_addr_q <= cpu_addr;
         rd_fly_q   <= rd_issue;
         vdg_fly_q  <= vdg_fetch;
         busy_q     <= busy_d;
         cpu_rvalid <= rd_fly_q;
         if (rd_fly_q) cpu_rdata <= ram_rdata;
         if (vdg_fly_q) vdg_dd <= ram_rdata;
         if (cpu_req && cpu_we && busy_q) wr_overflow <= 1'b1;
      end
   end

   assign cpu_busy = busy_q;

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Randomised and directed bench for mc10_vram_arbiter against a queue-based reference model.
module tb_mc10_vram_arbiter;

   localparam int AW     = 13;
   localparam int DW     = 8;
   localparam int WDEPTH = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          vdg_fetch = 1'b0;
   logic [AW-1:0] vdg_addr = '0;
   logic [DW-1:0] vdg_dd;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_busy, cpu_rvalid, wr_overflow;
   logic [DW-1:0] cpu_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   mc10_vram_arbiter #(.AW(AW), .DW(DW), .WDEPTH(WDEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .vdg_fetch   (vdg_fetch),
      .vdg_addr    (vdg_addr),
      .vdg_dd      (vdg_dd),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_busy    (cpu_busy),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .wr_overflow (wr_overflow),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   // Bench-side single-port RAM with one-cycle read latency; preload port has priority.
   bit [DW-1:0]   ram_mem [2**AW];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) ram_mem[pl_addr] <= pl_data;
      else if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else ram_rdata <= ram_mem[ram_addr];
      end
   end

   // Reference model state
   bit [DW-1:0]      ref_mem [2**AW];
   logic [AW+DW-1:0] wq [$];
   bit               m_rd_pend, m_rd_fly, m_vdg_fly, m_rvalid, m_ovf;
   logic [AW-1:0]    m_rd_addr;
   logic [DW-1:0]    m_rd_fly_d, m_vdg_fly_d, m_vdg_dd, m_rdata;

   int  checks = 0;
   int  errors = 0;
   bit  chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit rst, input bit f, input logic [AW-1:0] fa, input bit req,
                        input bit we, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      bit               e_busy, e_en, e_we, vis, ris;
      logic [AW-1:0]    e_addr;
      logic [DW-1:0]    e_wd, vdat, rdat;
      logic [AW+DW-1:0] ent;
      @(posedge clk);
      #1;
      reset_n   = rst;
      vdg_fetch = f;
      vdg_addr  = fa;
      cpu_req   = req;
      cpu_we    = we;
      cpu_addr  = ca;
      cpu_wdata = cd;
      #4;
      e_busy = (wq.size() == WDEPTH) || m_rd_pend || m_rd_fly;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      vis = 1'b0; ris = 1'b0; vdat = '0; rdat = '0;
      if (f) begin
         e_en = 1'b1; e_addr = fa; vis = 1'b1; vdat = ref_mem[fa];
      end else if (wq.size() > 0) begin
         ent = wq.pop_front();
         e_en = 1'b1; e_we = 1'b1; e_addr = ent[AW+DW-1:DW]; e_wd = ent[DW-1:0];
         ref_mem[e_addr] = e_wd;
      end else if (m_rd_pend) begin
         e_en = 1'b1; e_addr = m_rd_addr; ris = 1'b1; rdat = ref_mem[m_rd_addr];
         m_rd_pend = 1'b0;
      end
      if (pl_en) ref_mem[pl_addr] = pl_data;
      if (chk_on) begin
         chk("ram_en", ram_en, e_en);
         if (e_en) begin
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            if (e_we) chk("ram_wdata", ram_wdata, e_wd);
         end
         chk("vdg_dd", vdg_dd, m_vdg_dd);
         chk("cpu_rvalid", cpu_rvalid, m_rvalid);
         chk("cpu_rdata", cpu_rdata, m_rdata);
         chk("cpu_busy", cpu_busy, e_busy);
         chk("wr_overflow", wr_overflow, m_ovf);
      end
      if (m_vdg_fly) m_vdg_dd = m_vdg_fly_d;
      m_vdg_fly = vis; m_vdg_fly_d = vdat;
      m_rvalid = m_rd_fly;
      if (m_rd_fly) m_rdata = m_rd_fly_d;
      m_rd_fly = ris; m_rd_fly_d = rdat;
      if (req) begin
         if (e_busy) begin
            if (we) m_ovf = 1'b1;
         end else if (we) wq.push_back({ca, cd});
         else begin
            m_rd_pend = 1'b1; m_rd_addr = ca;
         end
      end
      if (!rst) begin
         wq.delete();
         m_rd_pend = 1'b0; m_rd_fly = 1'b0; m_vdg_fly = 1'b0;
         m_rvalid = 1'b0; m_ovf = 1'b0; m_vdg_dd = '0; m_rdata = '0;
      end
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
               AW'($urandom), DW'($urandom));
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      idle();
      pl_en = 1'b0;
   endtask

   initial begin
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk_on = 1'b1;

      // Reset with toggling inputs, then idle release
      do_reset(3);
      idle();
      chk("t1_vdg_dd", vdg_dd, 0);
      chk("t1_rvalid", cpu_rvalid, 0);
      chk("t1_busy", cpu_busy, 0);
      chk("t1_ovf", wr_overflow, 0);
      chk("t1_ram_en", ram_en, 0);

      for (int i = 0; i < 64; i++) preload(AW'(i), DW'($urandom));

      // VDG fetch latency
      preload(13'h0123, 8'hA5);
      cycle(1'b1, 1'b1, 13'h0123, 1'b0, 1'b0, '0, '0);
      chk("t2_ram_addr", ram_addr, 13'h0123);
      chk("t2_ram_we", ram_we, 0);
      idle();
      idle();
      chk("t2_vdg_dd", vdg_dd, 8'hA5);

      // FIFO fill under VDG starvation, overflow, then in-order drain
      do_reset(2);
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 1'b1, AW'(13'h1F00 + i), 1'b1, 1'b1, AW'(13'h0100 + i), DW'(8'h11 + i));
      chk("t3_busy_full", cpu_busy, 1);
      for (int j = 0; j < 4; j++) begin
         idle();
         chk("t3_ram_we", ram_we, 1);
         chk("t3_ram_addr", ram_addr, 13'h0100 + j);
         chk("t3_ram_wdata", ram_wdata, 8'h11 + j);
         chk("t3_ovf", wr_overflow, 1);
      end
      idle();
      chk("t3_drained", ram_en, 0);

      // Write then read same address
      do_reset(2);
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 13'h0040, 8'h3C);
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 13'h0040, '0);
      chk("t4_wr_first", ram_we, 1);
      chk("t4_wr_addr", ram_addr, 13'h0040);
      idle();
      chk("t4_rd_issue", ram_en & ~ram_we, 1);
      chk("t4_rd_addr", ram_addr, 13'h0040);
      idle();
      chk("t4_rvalid_early", cpu_rvalid, 0);
      idle();
      chk("t4_rvalid", cpu_rvalid, 1);
      chk("t4_rdata", cpu_rdata, 8'h3C);

      // VDG steals the read's slot
      do_reset(2);
      preload(13'h0200, 8'h5A);
      preload(13'h0300, 8'hC3);
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 13'h0200, '0);
      cycle(1'b1, 1'b1, 13'h0300, 1'b0, 1'b0, '0, '0);
      chk("t5_vdg_addr", ram_addr, 13'h0300);
      chk("t5_busy", cpu_busy, 1);
      idle();
      chk("t5_rd_addr", ram_addr, 13'h0200);
      chk("t5_rd_we", ram_we, 0);
      idle();
      chk("t5_vdg_dd", vdg_dd, 8'hC3);
      idle();
      chk("t5_rvalid", cpu_rvalid, 1);
      chk("t5_rdata", cpu_rdata, 8'h5A);
      chk("t5_busy_drop", cpu_busy, 0);

      // Reset during read flight
      do_reset(2);
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 13'h0600, '0);
      idle();
      chk("t6_issue", ram_addr, 13'h0600);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 13'h0700, 8'h99);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("t6_rvalid", cpu_rvalid, 0);
         chk("t6_busy", cpu_busy, 0);
         chk("t6_ram_en", ram_en, 0);
      end

      // Random traffic
      for (int i = 0; i < 3000; i++)
         cycle(1'($urandom_range(0, 599) != 0), 1'($urandom_range(0, 9) < 4),
               AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 6), AW'($urandom_range(0, 63)), DW'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
